// File: rtl/imm_field_stage.sv
// Decode-side stage ahead of the 20->32 sign extender: classifies format, extracts the immediate,
// and buffers through an output register plus one skid entry. Optional: IMM_ILLEGAL_CHK_EN.
module imm_field_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned IMM_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_instr,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_instr,
    output logic [XLEN-1:0]  out_pc,
    output logic [IMM_W-1:0] out_imm,
    output logic [2:0]       out_fmt
`ifdef IMM_ILLEGAL_CHK_EN
    ,
    output logic             out_illegal
`endif
);

    typedef enum logic [2:0] {FmtR = 3'd0, FmtI = 3'd1, FmtS = 3'd2, FmtB = 3'd3, FmtU = 3'd4,
                              FmtJ = 3'd5} fmt_e;

    typedef struct packed {
        logic [XLEN-1:0]  instr;
        logic [XLEN-1:0]  pc;
        logic [IMM_W-1:0] imm;
        fmt_e             fmt;
`ifdef IMM_ILLEGAL_CHK_EN
        logic             ill;
`endif
    } entry_t;

    entry_t in_entry;
    entry_t out_q, out_d, skid_q, skid_d;
    logic   out_valid_q, out_valid_d, skid_valid_q, skid_valid_d, in_ready_q, in_ready_d;
    logic   in_xfer, out_draining;
    fmt_e   in_fmt;
    logic   s;

    assign s = in_instr[31];

    always_comb begin
        in_fmt = FmtR;
        in_entry = '0;
        unique case (in_instr[6:0])
            7'b0110111, 7'b0010111:                                 in_fmt = FmtU;
            7'b1101111:                                             in_fmt = FmtJ;
            7'b1100111, 7'b0000011, 7'b0010011, 7'b1110011, 7'b0001111: in_fmt = FmtI;
            7'b0100011:                                             in_fmt = FmtS;
            7'b1100011:                                             in_fmt = FmtB;
            7'b0110011:                                             in_fmt = FmtR;
            default: begin
                in_fmt = FmtR;
`ifdef IMM_ILLEGAL_CHK_EN
                in_entry.ill = 1'b1;
`endif
            end
        endcase
`ifdef IMM_ILLEGAL_CHK_EN
        if (in_instr[1:0] != 2'b11) begin
            in_entry.ill = 1'b1;
            in_fmt = FmtR;
        end
`endif
        in_entry.instr = in_instr;
        in_entry.pc    = in_pc;
        in_entry.fmt   = in_fmt;
        // No shifting here: the consumer scales U by 12 and J/B by 1 after extension.
        case (in_fmt)
            FmtU:    in_entry.imm = in_instr[31:12];
            FmtJ:    in_entry.imm = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21]};
            FmtI:    in_entry.imm = {{8{s}}, in_instr[31:20]};
            FmtS:    in_entry.imm = {{8{s}}, in_instr[31:25], in_instr[11:7]};
            FmtB:    in_entry.imm = {{8{s}}, in_instr[31], in_instr[7], in_instr[30:25],
                                     in_instr[11:8]};
            default: in_entry.imm = '0;
        endcase
    end

    assign in_xfer      = in_valid && in_ready_q;
    assign out_draining = !out_valid_q || out_ready;

    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_draining) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = in_xfer;
                if (in_xfer) skid_d = in_entry;
            end else if (in_xfer) begin
                out_d       = in_entry;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_xfer) begin
            skid_d       = in_entry;
            skid_valid_d = 1'b1;
        end
        // Registered ready keeps decode back-pressure off the fetch-side combinational path.
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_instr = out_q.instr;
    assign out_pc    = out_q.pc;
    assign out_imm   = out_q.imm;
    assign out_fmt   = out_q.fmt;
`ifdef IMM_ILLEGAL_CHK_EN
    assign out_illegal = out_valid_q && out_q.ill;
`endif

endmodule

// File: tb/tb_imm_field_stage.sv
// Self-checking bench for imm_field_stage: a queue scoreboard of held instructions, checked
// against the DUT outputs each cycle. Exercises the out_illegal port when IMM_ILLEGAL_CHK_EN is set.
module tb_imm_field_stage;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, out_instr, out_pc;
    logic [19:0] out_imm;
    logic [2:0]  out_fmt;
`ifdef IMM_ILLEGAL_CHK_EN
    logic        out_illegal;
`endif

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [19:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    exp_t q[$];
    exp_t pend;
    int   errors = 0;
    int   checks = 0;

    imm_field_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .out_imm    (out_imm),
        .out_fmt    (out_fmt)
`ifdef IMM_ILLEGAL_CHK_EN
        ,
        .out_illegal(out_illegal)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [19:0] imm, input logic [2:0] fmt, input logic ill);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        pend     = '{instr, pc, imm, fmt, ill};
    endtask

    // Advance one clock and update the held-instruction model with the transfers at that edge.
    task automatic cycle();
        bit ix, ox;
        ix = in_valid && (q.size() < 2);
        ox = (q.size() > 0) && out_ready;
        @(posedge clk);
        if (flush) q.delete();
        else begin
            if (ox) void'(q.pop_front());
            if (ix) q.push_back(pend);
        end
        #1;
    endtask

    task automatic test_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", out_instr); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", out_pc); end
        checks++; if (out_imm !== 20'h0) begin errors++; $display("FAIL reset_imm: got %h want 0", out_imm); end
        checks++; if (out_fmt !== 3'd0) begin errors++; $display("FAIL reset_fmt: got %0d want 0", out_fmt); end
`ifdef IMM_ILLEGAL_CHK_EN
        checks++; if (out_illegal !== 1'b0) begin errors++; $display("FAIL reset_ill: got %b want 0", out_illegal); end
`endif
    endtask

    task automatic test_lui();
        out_ready = 1'b1;
        drive(32'h123450B7, 32'h0000_1000, 20'h12345, 3'd4, 1'b0);
        cycle();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lui_valid: got %b want 1", out_valid); end
        checks++; if (out_fmt !== 3'd4) begin errors++; $display("FAIL lui_fmt: got %0d want 4", out_fmt); end
        checks++; if (out_imm !== 20'h12345) begin errors++; $display("FAIL lui_imm: got %h want 12345", out_imm); end
        checks++; if (out_pc !== 32'h1000) begin errors++; $display("FAIL lui_pc: got %h want 1000", out_pc); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lui_ready: got %b want 1", in_ready); end
        cycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lui_drain: got %b want 0", out_valid); end
        checks++; if (out_imm !== 20'h12345) begin errors++; $display("FAIL lui_hold: got %h want 12345", out_imm); end
    endtask

    task automatic test_back_to_back();
        exp_t tbl[11];
        tbl[0]  = '{32'hFFDFF06F, 32'h100, 20'hFFFFE, 3'd5, 1'b0}; // jal x0,-4
        tbl[1]  = '{32'hFFF00093, 32'h104, 20'hFFFFF, 3'd1, 1'b0}; // addi x1,x0,-1
        tbl[2]  = '{32'h00202423, 32'h108, 20'h00008, 3'd2, 1'b0}; // sw x2,8(x0)
        tbl[3]  = '{32'hFE000EE3, 32'h10C, 20'hFFFFE, 3'd3, 1'b0}; // beq x0,x0,-4
        tbl[4]  = '{32'h002081B3, 32'h110, 20'h00000, 3'd0, 1'b0}; // add
        tbl[5]  = '{32'h00001117, 32'h114, 20'h00001, 3'd4, 1'b0}; // auipc
        tbl[6]  = '{32'hFE112E23, 32'h118, 20'hFFFFC, 3'd2, 1'b0}; // sw x1,-4(x2)
        tbl[7]  = '{32'h00812083, 32'h11C, 20'h00008, 3'd1, 1'b0}; // lw x1,8(x2)
        tbl[8]  = '{32'h0000007F, 32'h120, 20'h00000, 3'd0, 1'b1}; // unknown opcode
        tbl[9]  = '{32'hFFF00010, 32'h124, 20'h00000, 3'd0, 1'b1}; // low bits not 11
        tbl[10] = '{32'h00000073, 32'h128, 20'h00000, 3'd1, 1'b0}; // ecall
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].instr, tbl[i].pc, tbl[i].imm, tbl[i].fmt, tbl[i].ill);
            cycle();
            checks++; if (out_valid !== 1'b1 || q.size() != 1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, out_valid); end
            else begin
                checks++; if (out_instr !== q[0].instr) begin errors++; $display("FAIL b2b_instr[%0d]: got %h want %h", i, out_instr, q[0].instr); end
                checks++; if (out_imm !== q[0].imm) begin errors++; $display("FAIL b2b_imm[%0d]: got %h want %h", i, out_imm, q[0].imm); end
                checks++; if (out_fmt !== q[0].fmt) begin errors++; $display("FAIL b2b_fmt[%0d]: got %0d want %0d", i, out_fmt, q[0].fmt); end
`ifdef IMM_ILLEGAL_CHK_EN
                checks++; if (out_illegal !== q[0].ill) begin errors++; $display("FAIL b2b_ill[%0d]: got %b want %b", i, out_illegal, q[0].ill); end
`endif
            end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, in_ready); end
        end
        in_valid = 1'b0;
        cycle();
    endtask

    task automatic test_backpressure();
        logic [31:0] order[3];
        int got;
        bit acc;
        order = '{32'h00100093, 32'h00200113, 32'h00300193};
        out_ready = 1'b0;
        drive(order[0], 32'h200, 20'h1, 3'd1, 1'b0);
        cycle();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1: got %b want 1", in_ready); end
        drive(order[1], 32'h204, 20'h2, 3'd1, 1'b0);
        cycle();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready2: got %b want 0", in_ready); end
        drive(order[2], 32'h208, 20'h3, 3'd1, 1'b0);
        cycle();
        checks++; if (out_instr !== order[0]) begin errors++; $display("FAIL bp_hold: got %h want %h", out_instr, order[0]); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready3: got %b want 0", in_ready); end
        out_ready = 1'b1;
        got = 0;
        for (int k = 0; k < 8; k++) begin
            if (out_valid === 1'b1) begin
                checks++; if (got >= 3 || out_instr !== order[got]) begin errors++; $display("FAIL bp_order[%0d]: got %h want %h", got, out_instr, (got < 3) ? order[got] : 32'h0); end
                checks++; if (q.size() == 0 || out_imm !== q[0].imm) begin errors++; $display("FAIL bp_imm[%0d]: got %h want scoreboard head", got, out_imm); end
                got++;
            end
            checks++; if (in_ready !== (q.size() < 2)) begin errors++; $display("FAIL bp_ready_loop[%0d]: got %b want %b", k, in_ready, q.size() < 2); end
            acc = in_valid && (q.size() < 2);
            cycle();
            if (acc) in_valid = 1'b0;
        end
        checks++; if (got != 3) begin errors++; $display("FAIL bp_count: got %0d want 3", got); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(32'h00100093, 32'h300, 20'h1, 3'd1, 1'b0);
        cycle();
        drive(32'h00200113, 32'h304, 20'h2, 3'd1, 1'b0);
        cycle();
        drive(32'h00300193, 32'h308, 20'h3, 3'd1, 1'b0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush2_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush2_ready: got %b want 1", in_ready); end
        drive(32'h00400213, 32'h30C, 20'h4, 3'd1, 1'b0);
        cycle();
        drive(32'h00500293, 32'h310, 20'h5, 3'd1, 1'b0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush1_valid: got %b want 0", out_valid); end
        cycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_discard: got %b want 0", out_valid); end
        out_ready = 1'b1;
        drive(32'h00600313, 32'h314, 20'h6, 3'd1, 1'b0);
        cycle();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_instr !== 32'h00600313) begin errors++; $display("FAIL flush_after: got %b/%h want 1/00600313", out_valid, out_instr); end
        cycle();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(32'h00700393, 32'h400, 20'h7, 3'd1, 1'b0);
        cycle();
        drive(32'h00800413, 32'h404, 20'h8, 3'd1, 1'b0);
        cycle();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", in_ready); end
        checks++; if (out_imm !== 20'h0 || out_instr !== 32'h0) begin errors++; $display("FAIL rstmid_data: got %h/%h want 0/0", out_imm, out_instr); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        cycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_empty: got %b want 0", out_valid); end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        cycle();
        test_lui();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imm_field_stage.md
Name: imm_field_stage

Overview:
- Decode-side pipeline stage directly upstream of the 20→32 sign-extend unit.
- Accepts fetched instructions with PC over a valid/ready handshake and classifies the instruction format from the opcode.
- Extracts the immediate into a uniform 20-bit sign-carrying field for the extender, and presents it with instruction and PC to decode.
- Includes a 2-entry skid buffer so decode back-pressure never creates a combinational ready path to fetch.

Parameters:
- XLEN, 32, width of instruction and PC.
- IMM_W, 20, width of the extracted immediate field. Fixed at 20 to match the extender input.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  stage can accept. Registered.
- in_instr  input  XLEN  raw instruction.
- in_pc  input  XLEN  instruction address.
- flush  input  1  drop all held instructions (branch redirect).
- out_valid  output  1  output slot holds an instruction.
- out_ready  input  1  decode accepts.
- out_instr  output  XLEN  held instruction.
- out_pc  output  XLEN  held PC.
- out_imm  output  IMM_W  extracted immediate field, feeds the extender.
- out_fmt  output  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J.
- out_illegal  output  1  unrecognised opcode. Present only with the optional feature.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, in_ready=1, out_instr/out_pc/out_imm=0, out_fmt=0, out_illegal=0, skid entry empty.
- Input transfer: occurs when in_valid && in_ready. Output transfer: occurs when out_valid && out_ready.
- Latency: 1 cycle from input transfer to out_valid when the output slot is empty or draining.
- Storage is an output register plus one skid register.
  - Input transfer while the output register is occupied and not draining: the instruction goes to the skid register.
  - When the output drains and the skid register is full, the skid entry moves to the output register that cycle.
- in_ready is registered and equals !skid_full for the next cycle. At most 2 instructions are held.
- Simultaneous input and output transfer with both slots occupied: the skid entry moves to output and the new instruction enters skid. Order is preserved; skid stays full.
- Classification and extraction are computed at capture time and stored with the instruction, never recomputed at the output.
- Opcode map (instr[6:0]):
  - 0110111 and 0010111 → U.
  - 1101111 → J.
  - 1100111, 0000011, 0010011, 1110011, 0001111 → I.
  - 0100011 → S.
  - 1100011 → B.
  - 0110011 → R.
  - Any other opcode → R.
- out_imm per format (s = instr[31]):
  - U: instr[31:12].
  - J: {instr[31], instr[19:12], instr[20], instr[30:21]} = imm[20:1].
  - I: {{8{s}}, instr[31:20]}.
  - S: {{8{s}}, instr[31:25], instr[11:7]}.
  - B: {{8{s}}, instr[31], instr[7], instr[30:25], instr[11:8]} = imm[12:1] sign-extended.
  - R: 0.
- Consumer rule: after 32-bit sign extension, U is shifted left 12 and J/B are shifted left 1. This stage performs no shifting.
- flush: synchronous. On the next edge both slots are invalidated and in_ready=1. An input transfer in the same cycle as flush is discarded. flush has priority over all transfers.
- Reset mid-operation: immediate return to reset values and loss of held instructions.
- Data outputs hold their last value while out_valid=0.

Optional Feature:
- Macro: IMM_ILLEGAL_CHK_EN.
- Defined:
  - out_illegal port exists.
  - Asserted with out_valid for any opcode outside the map, or when instr[1:0] != 2'b11.
  - For such instructions out_fmt=R and out_imm=0.
  - Cleared on reset and flush.
- Undefined: port absent; unknown opcodes are silently classified R.

Test Plan:
- LUI 0x123450B7, out_ready=1 → next cycle out_valid=1, out_fmt=4, out_imm=0x12345; in_ready stays 1.
- JAL x0,-4 0xFFDFF06F → out_fmt=5, out_imm=0xFFFFE (extender gives 0xFFFFFFFE, consumer shifts to -4).
- ADDI 0xFFF00093 then SW 0x00202423 back-to-back → out_imm 0xFFFFF fmt 1, then 0x00008 fmt 2, in order, one per cycle.
- out_ready=0 while sending 3 instructions → first two held, in_ready=0 after the second; release out_ready → delivered in order, third accepted after in_ready rises, no loss or duplication.
- Two instructions held, pulse flush with in_valid=1 → next cycle out_valid=0, in_ready=1, the same-cycle input is discarded.
- With IMM_ILLEGAL_CHK_EN: instr 0x0000007F → out_illegal=1, out_fmt=0, out_imm=0. Without the macro → out_fmt=0, no illegal port.
